// File: rtl/q0_inv_lut_if.sv
// Byte lookup stream for q0_inv_lut: request channel (in_*) and result channel (out_*).
interface q0_inv_lut_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;

    modport master (
        output in_valid, in_byte, out_ready,
        input  in_ready, out_valid, out_byte
    );

    modport slave (
        input  in_valid, in_byte, out_ready,
        output in_ready, out_valid, out_byte
    );
endinterface

// File: rtl/q0_inv_lut.sv
// Inverse Twofish q0 lookup: builds inv[q0(i)] = i after reset, then serves byte lookups.
// Define Q0_INV_VERIFY_EN to add a post-build self-check sweep that drives init_err.
module q0_inv_lut (
    input  logic            clk,
    input  logic            rst,
    q0_inv_lut_if.slave     bus,
    output logic            busy,
    output logic            init_err
);

    typedef enum logic [1:0] {FILL, VERIFY, RUN} state_t;

    localparam logic [3:0] T0 [16] = '{4'h8, 4'h1, 4'h7, 4'hD, 4'h6, 4'hF, 4'h3, 4'h2,
                                       4'h0, 4'hB, 4'h5, 4'h9, 4'hE, 4'hC, 4'hA, 4'h4};
    localparam logic [3:0] T1 [16] = '{4'hE, 4'hC, 4'hB, 4'h8, 4'h1, 4'h2, 4'h3, 4'h5,
                                       4'hF, 4'h4, 4'hA, 4'h6, 4'h7, 4'h0, 4'h9, 4'hD};
    localparam logic [3:0] T2 [16] = '{4'hB, 4'hA, 4'h5, 4'hE, 4'h6, 4'hD, 4'h9, 4'h0,
                                       4'hC, 4'h8, 4'hF, 4'h3, 4'h2, 4'h4, 4'h7, 4'h1};
    localparam logic [3:0] T3 [16] = '{4'hD, 4'h7, 4'hF, 4'h4, 4'h1, 4'h2, 4'h6, 4'hE,
                                       4'h9, 4'hB, 4'h3, 4'h0, 4'h8, 4'h5, 4'hC, 4'hA};

    // Forward q0 nibble network; result packs {b4, a4}.
    function automatic logic [7:0] q0(input logic [7:0] x);
        logic [3:0] a1, b1, a2, b2, a3, b3;
        a1 = x[7:4] ^ x[3:0];
        b1 = x[7:4] ^ {x[0], x[3:1]} ^ {x[4], 3'b000};
        a2 = T0[a1];
        b2 = T1[b1];
        a3 = a2 ^ b2;
        b3 = a2 ^ {b2[0], b2[3:1]} ^ {a2[0], 3'b000};
        return {T3[b3], T2[a3]};
    endfunction

    state_t     state;
    logic [7:0] i;
    logic [7:0] inv [256];
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       run;
    logic       accept;
    logic       ovalid;
    logic [7:0] obyte;

    assign run          = (state == RUN);
    assign busy         = ~run;
    assign bus.in_ready = run & (~ovalid | bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;
    assign bus.out_valid = ovalid;
    assign bus.out_byte  = obyte;

    always_ff @(posedge clk) begin
        if (state == FILL)
            inv[q0(i)] <= i;
    end

`ifdef Q0_INV_VERIFY_EN
    logic [8:0] vcnt;
    logic [7:0] vdata;
    logic [7:0] chk_idx;
    logic       chk_valid;

    // The verify sweep and lookups share the single read port.
    assign rd_addr = run ? bus.in_byte : vcnt[7:0];
    assign rd_data = inv[rd_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            i         <= 8'h00;
            vcnt      <= 9'd0;
            vdata     <= 8'h00;
            chk_idx   <= 8'h00;
            chk_valid <= 1'b0;
            init_err  <= 1'b0;
        end else begin
            unique case (state)
                FILL: begin
                    if (i == 8'hFF) state <= VERIFY;
                    else            i     <= i + 8'd1;
                end
                VERIFY: begin
                    vcnt      <= vcnt + 9'd1;
                    vdata     <= rd_data;
                    chk_idx   <= vcnt[7:0];
                    chk_valid <= ~vcnt[8];
                    if (chk_valid && (q0(vdata) != chk_idx))
                        init_err <= 1'b1;
                    if (vcnt[8]) state <= RUN;
                end
                RUN: ;
                default: state <= FILL;
            endcase
        end
    end
`else
    assign rd_addr  = bus.in_byte;
    assign rd_data  = inv[rd_addr];
    assign init_err = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
            i     <= 8'h00;
        end else begin
            unique case (state)
                FILL: begin
                    if (i == 8'hFF) state <= RUN;
                    else            i     <= i + 8'd1;
                end
                RUN: ;
                default: state <= FILL;
            endcase
        end
    end
`endif

    // Accept takes priority over drain so a same-cycle pair keeps full throughput.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovalid <= 1'b0;
            obyte  <= 8'h00;
        end else if (accept) begin
            ovalid <= 1'b1;
            obyte  <= rd_data;
        end else if (bus.out_ready) begin
            ovalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_q0_inv_lut.sv
// Directed bench for q0_inv_lut: build timing, known vectors, round trip, backpressure, resets.
module tb_q0_inv_lut;

`ifdef Q0_INV_VERIFY_EN
    localparam int BUSY_LEN = 513;
`else
    localparam int BUSY_LEN = 256;
`endif

    logic clk;
    logic rst;
    logic busy;
    logic init_err;
    int   n_assert;
    int   n_fail;

    q0_inv_lut_if bus ();

    q0_inv_lut dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .init_err (init_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference q0 from packed nibble tables (entry 0 in the top nibble).
    function automatic logic [7:0] ref_q0(input logic [7:0] x);
        logic [63:0] t0, t1, t2, t3;
        logic [3:0]  a, b, na, nb;
        t0 = 64'h817D6F320B59ECA4;
        t1 = 64'hECB81235F4A6709D;
        t2 = 64'hBA5E6D90C8F32471;
        t3 = 64'hD7F4126E9B3085CA;
        a  = x >> 4;
        b  = x & 8'h0F;
        na = a ^ b;
        nb = a ^ (((b >> 1) | (b << 3)) & 4'hF) ^ ((a << 3) & 4'hF);
        a  = (t0 >> (4 * (15 - na))) & 64'hF;
        b  = (t1 >> (4 * (15 - nb))) & 64'hF;
        na = a ^ b;
        nb = a ^ (((b >> 1) | (b << 3)) & 4'hF) ^ ((a << 3) & 4'hF);
        a  = (t2 >> (4 * (15 - na))) & 64'hF;
        b  = (t3 >> (4 * (15 - nb))) & 64'hF;
        return {b, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until busy falls, watching the stream outputs stay quiet.
    task automatic wait_idle(output int n, output logic ir_bad, output logic ov_bad);
        n = 0;
        ir_bad = 1'b0;
        ov_bad = 1'b0;
        while (busy === 1'b1 && n < 2000) begin
            if (bus.in_ready !== 1'b0)  ir_bad = 1'b1;
            if (bus.out_valid !== 1'b0) ov_bad = 1'b1;
            step();
            n++;
        end
    endtask

    logic [7:0] kin [4];
    logic [7:0] y;
    int         n;
    logic       ir_bad;
    logic       ov_bad;

    initial begin
        n_assert = 0;
        n_fail   = 0;
        kin      = '{8'hA9, 8'h67, 8'hB3, 8'hE8};
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_byte   = 8'h00;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("rst_busy", busy, 1);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_byte", bus.out_byte, 8'h00);
        chk("rst_init_err", init_err, 0);

        // Build after reset release, with a request already waiting.
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'hA9;
        bus.out_ready = 1'b1;
        rst = 1'b0;
        wait_idle(n, ir_bad, ov_bad);
        chk("build_len", n, BUSY_LEN);
        chk("build_in_ready_low", ir_bad, 0);
        chk("build_out_valid_low", ov_bad, 0);
        chk("build_init_err", init_err, 0);
        chk("run_in_ready", bus.in_ready, 1);

        // Known vectors, back-to-back.
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_byte  = kin[k];
            #1;
            chk("vec_in_ready", bus.in_ready, 1);
            step();
            chk("vec_out_valid", bus.out_valid, 1);
            chk("vec_out_byte", bus.out_byte, k);
        end
        bus.in_valid = 1'b0;
        step();
        chk("vec_drained", bus.out_valid, 0);

        // Round trip through the reference forward q0.
        for (int x = 0; x < 256; x++) begin
            y = ref_q0(x[7:0]);
            bus.in_valid = 1'b1;
            bus.in_byte  = y;
            step();
            chk("rt_out_valid", bus.out_valid, 1);
            chk("rt_out_byte", bus.out_byte, x);
        end
        bus.in_valid = 1'b0;
        step();
        chk("rt_drained", bus.out_valid, 0);

        // Backpressure: hold a result, keep a second request pending.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_byte   = 8'hA9;
        step();
        bus.in_byte = 8'h67;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_out_byte", bus.out_byte, 8'h00);
            chk("bp_in_ready", bus.in_ready, 0);
            step();
        end
        chk("bp_hold_last", bus.out_byte, 8'h00);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", bus.in_ready, 1);
        step();
        chk("bp_next_valid", bus.out_valid, 1);
        chk("bp_next_byte", bus.out_byte, 8'h01);
        bus.in_valid = 1'b0;
        step();
        chk("bp_drained", bus.out_valid, 0);

        // Reset mid-RUN with a pending result.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_byte   = 8'hB3;
        step();
        bus.in_valid = 1'b0;
        chk("mr_pending_valid", bus.out_valid, 1);
        chk("mr_pending_byte", bus.out_byte, 8'h02);
        rst = 1'b1;
        #1;
        chk("mr_out_valid", bus.out_valid, 0);
        chk("mr_out_byte", bus.out_byte, 8'h00);
        chk("mr_busy", busy, 1);
        chk("mr_in_ready", bus.in_ready, 0);
        step();
        rst = 1'b0;

        // Reset mid-FILL at i = 100, then a full rebuild.
        repeat (100) step();
        chk("mf_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        chk("mf_busy", busy, 1);
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        wait_idle(n, ir_bad, ov_bad);
        chk("mf_build_len", n, BUSY_LEN);
        chk("mf_in_ready_low", ir_bad, 0);
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'hE8;
        step();
        bus.in_valid = 1'b0;
        chk("mf_lookup_valid", bus.out_valid, 1);
        chk("mf_lookup_byte", bus.out_byte, 8'h03);
        step();

`ifdef Q0_INV_VERIFY_EN
        // Corrupt one entry during the verify sweep.
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (300) step();
        chk("ve_busy_mid", busy, 1);
        dut.inv[8'hA9] = 8'h05;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            step();
            n++;
        end
        chk("ve_done", busy, 0);
        chk("ve_init_err", init_err, 1);
        repeat (10) step();
        chk("ve_sticky", init_err, 1);
        rst = 1'b1;
        #1;
        chk("ve_rst_clear", init_err, 0);
        step();
        rst = 1'b0;
        wait_idle(n, ir_bad, ov_bad);
        chk("ve_rebuild_len", n, BUSY_LEN);
        chk("ve_rebuild_err", init_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
